// File: rtl/result_fifo_drain_packer_if.sv
// rtl/result_fifo_drain_packer_if.sv - result FIFO read side and result buffer write side of the drain packer
interface result_fifo_drain_packer_if #(
    parameter int DATA_W      = 16,
    parameter int LINES_LANES = 16,
    parameter int ADDR_W      = 11
);
    localparam int LINE_W = DATA_W * LINES_LANES;

    logic                   o_fifo_rd_en;
    logic [DATA_W-1:0]      i_fifo_rd_data;
    logic                   i_fifo_empty;
    logic                   o_wr_en;
    logic [ADDR_W-1:0]      o_wr_addr;
    logic [LINE_W-1:0]      o_wr_data;
    logic [LINES_LANES-1:0] o_wr_lane_mask;
    logic                   i_wr_ready;

    modport master (
        output o_fifo_rd_en,
        input  i_fifo_rd_data,
        input  i_fifo_empty,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data,
        output o_wr_lane_mask,
        input  i_wr_ready
    );

    modport slave (
        input  o_fifo_rd_en,
        output i_fifo_rd_data,
        output i_fifo_empty,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_wr_lane_mask,
        output i_wr_ready
    );
endinterface

// File: rtl/result_fifo_drain_packer.sv
// rtl/result_fifo_drain_packer.sv - drains FP16 results from the result FIFO and packs them into 256-bit buffer lines
module result_fifo_drain_packer #(
    parameter int DATA_W      = 16,
    parameter int LINES_LANES = 16,
    parameter int ADDR_W      = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [15:0]           i_expected_count,
    input  logic [ADDR_W-1:0]     i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_drain_count,
    output logic [2:0]            o_state,
    output logic                  o_err_start_busy,
    result_fifo_drain_packer_if.master bus
);
    localparam int LINE_W = DATA_W * LINES_LANES;
    localparam int LANE_W = $clog2(LINES_LANES);
    localparam logic [LANE_W:0] LINE_FULL = (LANE_W+1)'(LINES_LANES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [15:0]            r_expected;
    logic [15:0]            r_issued;
    logic [15:0]            r_captured;
    logic [LANE_W:0]        r_issued_in_line;
    logic [ADDR_W-1:0]      r_addr;
    logic [LINE_W-1:0]      r_lanes;
    logic                   r_rd_pending;
    logic                   r_err_start_busy;

    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_done;
    logic                   w_busy;
    logic                   w_line_done;
    logic [LANE_W-1:0]      w_lane;
    logic [LINES_LANES-1:0] w_mask;

    // The capture slot is the low bits of the job-wide capture count; lines always start on a 16-result boundary.
    assign w_lane      = r_captured[LANE_W-1:0];
    assign w_line_done = r_rd_pending &&
                         ((w_lane == {LANE_W{1'b1}}) || (r_captured + 16'd1 == r_expected));

    // A capture count that is a multiple of 16 inside WRITE means a full line; otherwise the low bits give the partial size.
    always_comb begin
        w_mask = '0;
        if (r_state == WRITE) begin
            if (w_lane == '0) w_mask = '1;
            else              w_mask = (LINES_LANES'(1) << w_lane) - LINES_LANES'(1);
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state and handshake outputs; the FIFO is never popped outside DRAIN.
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = (i_expected_count == 16'd0) ? DONE : DRAIN;
            end
            DRAIN: begin
                w_busy  = 1'b1;
                w_rd_en = !bus.i_fifo_empty && (r_issued < r_expected) && (r_issued_in_line < LINE_FULL);
                if (w_line_done) w_next_state = WRITE;
            end
            WRITE: begin
                w_busy  = 1'b1;
                w_wr_en = 1'b1;
                if (bus.i_wr_ready) w_next_state = (r_captured == r_expected) ? DONE : DRAIN;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Job datapath: pop bookkeeping, lane capture one cycle after each pop, line retire on write acceptance.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_expected       <= '0;
            r_issued         <= '0;
            r_captured       <= '0;
            r_issued_in_line <= '0;
            r_addr           <= '0;
            r_lanes          <= '0;
            r_rd_pending     <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_expected       <= i_expected_count;
            r_addr           <= i_base_addr;
            r_issued         <= '0;
            r_captured       <= '0;
            r_issued_in_line <= '0;
            r_lanes          <= '0;
            r_rd_pending     <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_en;
            if (w_rd_en) begin
                r_issued         <= r_issued + 16'd1;
                r_issued_in_line <= r_issued_in_line + (LANE_W+1)'(1);
            end
            if (r_rd_pending) begin
                r_lanes[w_lane*DATA_W +: DATA_W] <= bus.i_fifo_rd_data;
                r_captured                       <= r_captured + 16'd1;
            end
            if (r_state == WRITE && bus.i_wr_ready) begin
                r_lanes          <= '0;
                r_issued_in_line <= '0;
                r_addr           <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Sticky flag for a start request that arrives while a job is still in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                     r_err_start_busy <= 1'b0;
        else if (i_start && r_state != IDLE) r_err_start_busy <= 1'b1;
    end

    assign o_busy             = w_busy;
    assign o_done             = w_done;
    assign o_drain_count      = r_captured;
    assign o_state            = r_state;
    assign o_err_start_busy   = r_err_start_busy;
    assign bus.o_fifo_rd_en   = w_rd_en;
    assign bus.o_wr_en        = w_wr_en;
    assign bus.o_wr_addr      = r_addr;
    assign bus.o_wr_data      = r_lanes;
    assign bus.o_wr_lane_mask = w_mask;
endmodule

// File: tb/tb_result_fifo_drain_packer.sv
// tb/tb_result_fifo_drain_packer.sv - vector-table bench for result_fifo_drain_packer
module tb_result_fifo_drain_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] exp_count = '0;
    logic [10:0] base = '0;
    logic        busy, done, err;
    logic [15:0] drain_count;
    logic [2:0]  state;

    result_fifo_drain_packer_if #(.DATA_W(16), .LINES_LANES(16), .ADDR_W(11)) bus ();

    result_fifo_drain_packer #(.DATA_W(16), .LINES_LANES(16), .ADDR_W(11)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start          (start),
        .i_expected_count (exp_count),
        .i_base_addr      (base),
        .o_busy           (busy),
        .o_done           (done),
        .o_drain_count    (drain_count),
        .o_state          (state),
        .o_err_start_busy (err),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] fifo_q[$];
    int push_idx = 0;
    int trickle_left = 0;
    int trickle_ph = 0;
    int stall_left = 0;

    logic [10:0]  log_addr[$];
    logic [255:0] log_data[$];
    logic [15:0]  log_mask[$];
    int pops, pop_empty, pops_in_write, stall_cyc, stab_err, done_cnt;
    int first_pop, last_pop, acc_cyc, done_cyc, start_cyc;
    logic         prev_stall = 1'b0;
    logic [10:0]  prev_addr;
    logic [255:0] prev_data;
    logic [15:0]  prev_mask;

    initial begin
        bus.i_fifo_rd_data = '0;
        bus.i_fifo_empty   = 1'b1;
        bus.i_wr_ready     = 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read FIFO model with optional slow producer (one word every 3 cycles).
    always @(posedge clk) begin
        if (bus.o_fifo_rd_en && fifo_q.size() > 0) bus.i_fifo_rd_data <= fifo_q.pop_front();
        if (trickle_left > 0) begin
            if (trickle_ph == 2) begin
                fifo_q.push_back(16'h3C00 + 16'(push_idx));
                push_idx++;
                trickle_left--;
                trickle_ph = 0;
            end else trickle_ph++;
        end
        bus.i_fifo_empty <= (fifo_q.size() == 0);
    end

    // Write sink and observation, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.o_wr_en && stall_left > 0) begin
            bus.i_wr_ready = 1'b0;
            stall_left--;
        end else bus.i_wr_ready = 1'b1;
        if (rst_n) begin
            if (bus.o_fifo_rd_en) begin
                if (bus.i_fifo_empty) pop_empty++;
                if (state == 3'd2) pops_in_write++;
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (prev_stall && (!bus.o_wr_en || bus.o_wr_addr != prev_addr ||
                               bus.o_wr_data != prev_data || bus.o_wr_lane_mask != prev_mask))
                stab_err++;
            prev_stall = bus.o_wr_en && !bus.i_wr_ready;
            prev_addr  = bus.o_wr_addr;
            prev_data  = bus.o_wr_data;
            prev_mask  = bus.o_wr_lane_mask;
            if (bus.o_wr_en && !bus.i_wr_ready) stall_cyc++;
            if (bus.o_wr_en && bus.i_wr_ready) begin
                log_addr.push_back(bus.o_wr_addr);
                log_data.push_back(bus.o_wr_data);
                log_mask.push_back(bus.o_wr_lane_mask);
                acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_mask.delete();
        pops = 0; pop_empty = 0; pops_in_write = 0; stall_cyc = 0; stab_err = 0; done_cnt = 0;
        first_pop = -1; last_pop = -1; acc_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0;
    endtask

    task automatic fifo_load(input int n);
        fifo_q.delete();
        push_idx = 0;
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(16'h3C00 + 16'(push_idx));
            push_idx++;
        end
        bus.i_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({nm, " done reached"}, done_cnt != 0, 1);
        @(negedge clk);
    endtask

    function automatic logic [255:0] model_line(input int cnt, input int j);
        logic [255:0] l = '0;
        for (int k = 0; k < 16; k++)
            if (j * 16 + k < cnt) l[k*16 +: 16] = 16'h3C00 + 16'(j * 16 + k);
        return l;
    endfunction

    typedef struct {
        int          cnt;
        int          base;
        int          preload;
        int          trickle;
        int          stall;
        int          nwr;
        int          addr0;
        int          addr1;
        logic [15:0] mask_last;
        int          left;
        int          span;
    } vec_t;

    vec_t vecs[6];
    string nm;

    initial begin
        vecs[0] = '{cnt:16, base:5,    preload:16, trickle:0,  stall:0,  nwr:1, addr0:5,    addr1:0,   mask_last:16'hFFFF, left:0, span:15};
        vecs[1] = '{cnt:20, base:100,  preload:21, trickle:0,  stall:0,  nwr:2, addr0:100,  addr1:101, mask_last:16'h000F, left:1, span:-1};
        vecs[2] = '{cnt:16, base:7,    preload:16, trickle:0,  stall:10, nwr:1, addr0:7,    addr1:0,   mask_last:16'hFFFF, left:0, span:15};
        vecs[3] = '{cnt:16, base:9,    preload:0,  trickle:16, stall:0,  nwr:1, addr0:9,    addr1:0,   mask_last:16'hFFFF, left:0, span:-1};
        vecs[4] = '{cnt:32, base:2047, preload:32, trickle:0,  stall:0,  nwr:2, addr0:2047, addr1:0,   mask_last:16'hFFFF, left:0, span:-1};
        vecs[5] = '{cnt:0,  base:3,    preload:4,  trickle:0,  stall:0,  nwr:0, addr0:0,    addr1:0,   mask_last:16'h0000, left:4, span:-1};

        clear_logs();
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_en", bus.o_fifo_rd_en, 0);
        chk("reset wr_en", bus.o_wr_en, 0);
        chk("reset wr_data", bus.o_wr_data, 0);
        chk("reset mask", bus.o_wr_lane_mask, 0);
        chk("reset state", state, 0);
        chk("reset drain_count", drain_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            fifo_load(vecs[v].preload);
            trickle_ph = 0;
            trickle_left = vecs[v].trickle;
            clear_logs();
            stall_left = vecs[v].stall;
            exp_count = 16'(vecs[v].cnt);
            base = 11'(vecs[v].base);
            start = 1'b1;
            start_cyc = cyc;
            @(negedge clk);
            start = 1'b0;
            wait_done($sformatf("v%0d", v), 3000);
            nm = $sformatf("v%0d ", v);
            chk({nm, "done pulses"}, done_cnt, 1);
            chk({nm, "write count"}, log_addr.size(), vecs[v].nwr);
            if (log_addr.size() > 0) chk({nm, "addr0"}, log_addr[0], vecs[v].addr0);
            if (log_addr.size() > 1) chk({nm, "addr1"}, log_addr[1], vecs[v].addr1);
            for (int j = 0; j < log_addr.size(); j++) begin
                chk($sformatf("v%0d line%0d data", v, j), log_data[j], model_line(vecs[v].cnt, j));
                chk($sformatf("v%0d line%0d mask", v, j), log_mask[j],
                    (j == log_addr.size() - 1) ? vecs[v].mask_last : 16'hFFFF);
            end
            chk({nm, "pops"}, pops, vecs[v].cnt);
            chk({nm, "fifo leftover"}, fifo_q.size(), vecs[v].left);
            chk({nm, "drain_count"}, drain_count, vecs[v].cnt);
            if (vecs[v].nwr > 0) chk({nm, "done after accept"}, done_cyc - acc_cyc, 1);
            else                 chk({nm, "done after start"}, done_cyc - start_cyc, 1);
            chk({nm, "pop while empty"}, pop_empty, 0);
            chk({nm, "pops during write"}, pops_in_write, 0);
            chk({nm, "stall cycles"}, stall_cyc, vecs[v].stall);
            chk({nm, "stall stability"}, stab_err, 0);
            if (vecs[v].preload > 0 && vecs[v].cnt > 0) chk({nm, "first pop latency"}, first_pop - start_cyc, 1);
            if (vecs[v].span >= 0) chk({nm, "pop burst span"}, last_pop - first_pop, vecs[v].span);
            chk({nm, "busy after done"}, busy, 0);
            chk({nm, "err flag"}, err, 0);
            trickle_left = 0;
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a job, after 7 captures.
        fifo_load(16);
        clear_logs();
        exp_count = 16'd16;
        base = 11'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && drain_count != 16'd7; n++) @(negedge clk);
        chk("midjob captures", drain_count, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("midjob reset outs", {busy, done, bus.o_fifo_rd_en, bus.o_wr_en, err, state}, 0);
        chk("midjob reset data", bus.o_wr_data, 0);
        chk("midjob reset count", drain_count, 0);
        chk("midjob no write", log_addr.size(), 0);
        chk("midjob no done", done_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh job with a stray start while busy.
        fifo_load(16);
        clear_logs();
        exp_count = 16'd16;
        base = 11'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("err before stray start", err, 0);
        exp_count = 16'd5;
        base = 11'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err after stray start", err, 1);
        wait_done("recover", 500);
        chk("recover writes", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            chk("recover addr", log_addr[0], 9);
            chk("recover data", log_data[0], model_line(16, 0));
            chk("recover mask", log_mask[0], 16'hFFFF);
        end
        chk("recover drain_count", drain_count, 16);
        chk("recover err sticky", err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
